// File: rtl/pwm_pkg.sv
// pwm_pkg: shared FSM encoding, default widths and helpers for the PWM channel
// Contents: state_t with IDLE/RUN/DRAIN, default BITS/PRE_BITS, pwm_active() state decode.
package pwm_pkg;
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t RUN = 2'd1;
  localparam state_t DRAIN = 2'd2;
  localparam int DEF_BITS = 8;
  localparam int DEF_PRE_BITS = 4;
  function automatic logic pwm_active(state_t s);
    return s != IDLE;
  endfunction
endpackage

// File: rtl/pwm_ctrl_if.sv
// pwm_ctrl_if: config offer/accept handshake between the CPU side and the PWM channel
// Signals: cfg_valid/cfg_ready handshake; cfg_period, cfg_duty, cfg_prescale, cfg_oneshot payload.
// Modports: master drives the offer, slave (pwm_ctrl) returns cfg_ready.
interface pwm_ctrl_if import pwm_pkg::*; #(
  parameter int BITS = DEF_BITS,
  parameter int PRE_BITS = DEF_PRE_BITS
);
  logic cfg_valid;
  logic cfg_ready;
  logic [BITS-1:0] cfg_period;
  logic [BITS-1:0] cfg_duty;
  logic [PRE_BITS-1:0] cfg_prescale;
  logic cfg_oneshot;
  modport master (
    output cfg_valid, cfg_period, cfg_duty, cfg_prescale, cfg_oneshot,
    input cfg_ready
  );
  modport slave (
    input cfg_valid, cfg_period, cfg_duty, cfg_prescale, cfg_oneshot,
    output cfg_ready
  );
endinterface

// File: rtl/pwm_tick_gen.sv
// pwm_tick_gen: prescaler counting 0..reload while enabled, pulsing tick on the terminal count
// Ports: clk, rst (async, active-high); en counts; clr forces the count to 0; reload terminal count; tick pulse.
module pwm_tick_gen import pwm_pkg::*; #(
  parameter int PRE_BITS = DEF_PRE_BITS
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  input  logic [PRE_BITS-1:0] reload,
  output logic tick
);
  logic [PRE_BITS-1:0] cnt;
  assign tick = en && cnt == reload;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + PRE_BITS'(1);
endmodule

// File: rtl/pwm_ctrl.sv
// pwm_ctrl: single-channel PWM sequencer with double-buffered config landing on period boundaries
// Ports: clk, rst (async, active-high); start/stop run control; cfg (pwm_ctrl_if.slave) config handshake;
//        pwm_out registered waveform; busy (not IDLE); tick prescaler pulse; period_done end-of-period pulse.
// Macro PWM_POLARITY_EN adds input pol, XORed into pwm_out so the idle level follows pol.
module pwm_ctrl import pwm_pkg::*; #(
  parameter int BITS = DEF_BITS,
  parameter int PRE_BITS = DEF_PRE_BITS
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic stop,
`ifdef PWM_POLARITY_EN
  input  logic pol,
`endif
  pwm_ctrl_if.slave cfg,
  output logic pwm_out,
  output logic busy,
  output logic tick,
  output logic period_done
);
  state_t state, state_nxt;
  logic pend, sh_oneshot, act_oneshot, go, copy, to_idle, pol_lvl;
  logic [BITS-1:0] sh_period, sh_duty, act_period, act_duty, cnt;
  logic [PRE_BITS-1:0] sh_pre, act_pre;
`ifdef PWM_POLARITY_EN
  assign pol_lvl = pol;
`else
  assign pol_lvl = 1'b0;
`endif
  assign busy = pwm_active(state);
  assign cfg.cfg_ready = !pend;
  assign period_done = tick && cnt == act_period;
  assign go = state == IDLE && start && !stop;
  // transfer needs !pend and copy needs pend, so the two never collide on pend
  assign copy = pend && (go || period_done);
  assign to_idle = busy && state_nxt == IDLE;
  always_comb
    state_nxt = state == IDLE  ? (go ? RUN : IDLE) :
                state == RUN   ? (period_done && (stop || act_oneshot) ? IDLE : stop ? DRAIN : RUN) :
                state == DRAIN ? (period_done ? IDLE : DRAIN) : IDLE;
  pwm_tick_gen #(.PRE_BITS(PRE_BITS)) u_tick (
    .clk(clk),
    .rst(rst),
    .en(busy),
    .clr(to_idle),
    .reload(act_pre),
    .tick(tick)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pend <= 1'b0;
      sh_period <= '0;
      sh_duty <= '0;
      sh_pre <= '0;
      sh_oneshot <= 1'b0;
      act_period <= '0;
      act_duty <= '0;
      act_pre <= '0;
      act_oneshot <= 1'b0;
    end else begin
      if (cfg.cfg_valid && !pend) begin
        sh_period <= cfg.cfg_period;
        sh_duty <= cfg.cfg_duty;
        sh_pre <= cfg.cfg_prescale;
        sh_oneshot <= cfg.cfg_oneshot;
        pend <= 1'b1;
      end
      if (copy) begin
        act_period <= sh_period;
        act_duty <= sh_duty;
        act_pre <= sh_pre;
        act_oneshot <= sh_oneshot;
        pend <= 1'b0;
      end
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (to_idle) cnt <= '0;
    else if (tick) cnt <= period_done ? '0 : cnt + BITS'(1);
  always_ff @(posedge clk or posedge rst)
    if (rst) pwm_out <= 1'b0;
    else pwm_out <= pol_lvl ^ (busy && cnt < act_duty);
endmodule

// File: tb/tb_pwm_ctrl.sv
// tb_pwm_ctrl: randomized scoreboard bench for pwm_ctrl against a period-level reference model
module tb_pwm_ctrl;
  localparam int BITS = 8;
  localparam int PB = 4;
  typedef struct {int p; int d; int pre; bit os;} cfg_t;
  typedef struct {int clks; int hi;} exp_t;
  logic clk = 0, rst = 0, start = 0, stop = 0;
  logic pwm_out, busy, tick, period_done;
  int checks = 0, failures = 0;
  exp_t exp_q[$];
  cfg_t act, sh, none, offered;
  bit pend, running, draining;
  int left, ndone;
  pwm_ctrl_if #(.BITS(BITS), .PRE_BITS(PB)) cfg_if ();
  pwm_ctrl #(.BITS(BITS), .PRE_BITS(PB)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .stop(stop),
`ifdef PWM_POLARITY_EN
    .pol(1'b0),
`endif
    .cfg(cfg_if),
    .pwm_out(pwm_out),
    .busy(busy),
    .tick(tick),
    .period_done(period_done)
  );
  always #5 clk = ~clk;
  function automatic cfg_t mk(int p, int d, int pre, bit os);
    cfg_t c;
    c.p = p;
    c.d = d;
    c.pre = pre;
    c.os = os;
    return c;
  endfunction
  function automatic int plen(cfg_t c);
    return (c.p + 1) * (c.pre + 1);
  endfunction
  function automatic int phigh(cfg_t c);
    return (c.d < c.p + 1 ? c.d : c.p + 1) * (c.pre + 1);
  endfunction
  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d at %0t", name, got, want, $time);
    end
  endtask
  task automatic push_period();
    exp_t e;
    e.clks = plen(act);
    e.hi = phigh(act);
    exp_q.push_back(e);
  endtask
  task automatic offer(cfg_t c);
    offered = c;
    cfg_if.cfg_period = c.p[BITS-1:0];
    cfg_if.cfg_duty = c.d[BITS-1:0];
    cfg_if.cfg_prescale = c.pre[PB-1:0];
    cfg_if.cfg_oneshot = c.os;
    cfg_if.cfg_valid = 1;
  endtask
  task automatic edge_step();
    bit done_m, tick_m, rdy_m, fin;
    int pos;
    pos = plen(act) - left;
    done_m = running && left == 1;
    tick_m = running && (pos % (act.pre + 1)) == act.pre;
    chk("busy", busy, running);
    chk("period_done", period_done, done_m);
    chk("tick", tick, tick_m);
    chk("cfg_ready", cfg_if.cfg_ready, !pend);
    rdy_m = !pend;
    if (!running && start && !stop) begin
      if (pend) begin act = sh; pend = 0; end
      running = 1;
      draining = 0;
      ndone = 0;
      left = plen(act);
      push_period();
    end else if (running) begin
      if (done_m) begin
        fin = stop || draining || act.os;
        ndone++;
        if (pend) begin act = sh; pend = 0; end
        if (fin) running = 0;
        else begin
          left = plen(act);
          push_period();
        end
      end else begin
        left--;
        if (stop) draining = 1;
      end
    end
    if (cfg_if.cfg_valid && rdy_m) begin sh = offered; pend = 1; end
    @(posedge clk);
    #3;
  endtask
  task automatic do_reset();
    start = 0;
    stop = 0;
    cfg_if.cfg_valid = 0;
    rst = 1;
    #1;
    chk("rst_pwm_out", pwm_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tick", tick, 0);
    chk("rst_period_done", period_done, 0);
    chk("rst_cfg_ready", cfg_if.cfg_ready, 1);
    act = none;
    sh = none;
    pend = 0;
    running = 0;
    draining = 0;
    exp_q.delete();
    @(posedge clk);
    #3;
    rst = 0;
  endtask
  task automatic run(cfg_t c, int nper, int stop_at, int mid_at, cfg_t mc, int rst_at, bit rnd);
    offer(c);
    edge_step();
    cfg_if.cfg_valid = 0;
    edge_step();
    start = 1;
    edge_step();
    start = 0;
    for (int cyc = 0; running && cyc < 3000; cyc++) begin
      if (cyc == rst_at) begin
        do_reset();
        break;
      end
      stop = stop_at >= 0 ? cyc == stop_at :
             (nper > 0 && ndone >= nper - 1 && (!rnd || $urandom_range(0, 2) == 0));
      start = rnd && $urandom_range(0, 7) == 0;
      if (cyc == mid_at) offer(mc);
      else cfg_if.cfg_valid = 0;
      edge_step();
    end
    if (running) begin
      failures++;
      $display("FAIL run_timeout busy=%0b required run end within budget", busy);
    end
    start = 0;
    stop = 0;
    cfg_if.cfg_valid = 0;
    repeat (2) edge_step();
  endtask
  initial begin
    int len, hi;
    bit busy_p, done_p;
    exp_t e;
    len = 0;
    hi = 0;
    busy_p = 0;
    done_p = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        len = 0;
        hi = 0;
        busy_p = 0;
        done_p = 0;
      end else begin
        if (busy_p) hi += int'(pwm_out);
        else chk("idle_pwm_out", pwm_out, 0);
        if (done_p) begin
          chk("period_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("period_clks", len, e.clks);
            chk("period_high", hi, e.hi);
          end
          len = 0;
          hi = 0;
        end
        if (busy) len++;
        busy_p = busy;
        done_p = period_done;
      end
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    cfg_t c, mc;
    cfg_if.cfg_valid = 0;
    cfg_if.cfg_period = '0;
    cfg_if.cfg_duty = '0;
    cfg_if.cfg_prescale = '0;
    cfg_if.cfg_oneshot = 0;
    #1;
    do_reset();
    run(mk(9, 3, 0, 0), 3, -1, -1, none, -1, 0);
    run(mk(3, 2, 1, 0), 2, -1, -1, none, -1, 0);
    run(mk(9, 3, 0, 0), 3, -1, 4, mk(9, 7, 0, 0), -1, 0);
    run(mk(4, 2, 0, 1), 0, -1, -1, none, -1, 0);
    run(mk(5, 3, 0, 0), 0, 2, -1, none, -1, 0);
    start = 1;
    stop = 1;
    edge_step();
    start = 0;
    stop = 0;
    repeat (2) edge_step();
    run(mk(9, 0, 0, 0), 2, -1, -1, none, -1, 0);
    run(mk(9, 200, 0, 0), 2, -1, -1, none, -1, 0);
    run(mk(9, 3, 0, 0), 0, -1, -1, none, 15, 0);
    repeat (60) begin
      c = mk($urandom_range(0, 12), $urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 4) == 0);
      mc = mk($urandom_range(0, 12), $urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 4) == 0);
      run(c, $urandom_range(1, 3), -1, $urandom_range(0, 1) == 1 ? int'($urandom_range(0, 30)) : -1, mc,
          $urandom_range(0, 9) == 0 ? int'($urandom_range(1, 30)) : -1, 1);
    end
    repeat (4) edge_step();
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pwm_ctrl.md
Name: pwm_ctrl

Overview:
- Sequencing controller for one PWM channel. It drives a prescaler timebase and a period/duty counter, and double-buffers configuration so changes land only at period boundaries.
- Provides start/stop/one-shot sequencing and a clean pwm_out waveform.
- Sits between the register/CPU-side config interface and the pin-level PWM output.

Parameters:
- BITS, 8, width of period, duty and period counter
- PRE_BITS, 4, width of prescaler reload and prescaler counter

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  level/pulse; begins a run when IDLE
- stop  input  1  requests graceful stop at the end of the current period
- cfg_valid  input  1  config offer
- cfg_ready  output  1  config accepted when cfg_valid & cfg_ready
- cfg_period  input  BITS  terminal count; period = cfg_period+1 ticks
- cfg_duty  input  BITS  high ticks per period
- cfg_prescale  input  PRE_BITS  tick every cfg_prescale+1 clocks
- cfg_oneshot  input  1  1 = stop automatically after one period
- pwm_out  output  1  registered PWM waveform
- busy  output  1  state != IDLE
- tick  output  1  prescaler tick pulse (RUN/DRAIN only)
- period_done  output  1  one-cycle pulse at the end of each period

Behaviour:
- Reset (async, rst=1): state=IDLE. pre_cnt, cnt, pwm_out, tick, period_done = 0. Active and shadow config = 0. pend=0, so cfg_ready=1.
- Config handshake:
  - cfg_ready = !pend.
  - On transfer: shadow <= cfg_*, pend <= 1.
  - Shadow -> active copy happens (a) on the IDLE->RUN transition if pend, or (b) in the cycle period_done=1 if pend; pend <= 0 on copy.
  - A transfer and a copy cannot coincide, since transfer needs pend=0 and copy needs pend=1.
- Prescaler:
  - In RUN/DRAIN, pre_cnt counts 0..pre_act; at pre_act it wraps to 0.
  - tick = (state!=IDLE) && pre_cnt==pre_act. With pre_act=0, tick is asserted every cycle.
- Period counter:
  - On tick, cnt <= (cnt==period_act) ? 0 : cnt+1.
  - period_done = tick && cnt==period_act. Combinational from registers, asserted the same cycle as the wrap.
- pwm_out (registered, 1-cycle latency):
  - pwm_out <= (state!=IDLE) && (cnt < duty_act).
  - Comparison is unsigned BITS-wide. duty_act=0 gives constant 0; duty_act>period_act gives constant 1 for the whole run.
- FSM:
  - IDLE: start && !stop -> RUN; pre_cnt and cnt are already 0. start && stop -> stay IDLE (stop wins).
  - RUN:
    - stop -> DRAIN.
    - period_done && oneshot_act -> IDLE.
    - stop and period_done in the same cycle -> IDLE.
    - start is ignored.
  - DRAIN: period_done -> IDLE. Further stop/start are ignored.
  - Entering IDLE: pre_cnt, cnt <= 0. pwm_out drops to 0 on the following edge. pend and shadow are preserved.
- The new active config takes effect in the first tick of the next period, which starts with cnt=0.
- rst asserted mid-run: immediate return to the reset values above, including discarding any pending shadow.

Optional Feature:
- Macro PWM_POLARITY_EN.
- Defined: adds port pol (input, 1, sampled each cycle). pwm_out register input becomes pol ^ ((state!=IDLE) && cnt<duty_act), so the IDLE level equals pol.
- Undefined: no pol port; behaviour as above, IDLE level 0.

Decomposition:
- Shared package pwm_pkg:
  - FSM state typedef/localparams: IDLE=2'd0, RUN=2'd1, DRAIN=2'd2.
  - Default config constants.
- Sub-module pwm_tick_gen: prescaler counter with enable, reload input and tick output.
- Period/duty logic, shadow registers and FSM stay in pwm_ctrl.

Test Plan:
- Reset then cfg {period=9, duty=3, pre=0, oneshot=0}, start -> pwm_out high 3 clk / low 7 clk repeating; period_done every 10 clk; cfg_ready 0 until start, then 1.
- pre=1, period=3, duty=2 -> tick every 2nd clk; pwm_out high 4 clk / low 4 clk; period_done every 8 clk.
- Running duty=3, then load duty=7 mid-period -> current period keeps 3-tick high; change applies from the cycle after period_done; cfg_ready low in between.
- oneshot=1, period=4, duty=2 -> exactly one 2-high/3-low period, then busy=0 and period_done pulsed once.
- stop asserted at cnt=2 of period=5 -> DRAIN until cnt=5 tick, then IDLE; start and stop together in IDLE -> busy stays 0.
- Edge duties and mid-run reset: duty=0 -> pwm_out constant 0; duty=200 with period=9 -> constant 1 while busy; rst pulse mid-run -> all outputs 0 and cfg_ready=1 immediately.
